// File: rtl/knn_vote_pkg.sv
// Shared definitions for the knn_vote majority-vote classifier.
package knn_vote_pkg;

  // Default geometry, matched to the knn solver array depth and label set.
  localparam int KV_HW_K      = 10;
  localparam int KV_N_CLASSES = 10;
  localparam int KV_LABEL_W   = 8;

  // Job sequencing states.
  typedef enum logic [1:0] {
    KV_IDLE    = 2'd0,
    KV_COLLECT = 2'd1,
    KV_SCAN    = 2'd2,
    KV_DONE    = 2'd3
  } kv_state_e;

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote histogram: a count and the position of the first (nearest)
// occurrence for every class, with a job clear, a single increment port and
// an indexed read port used while scanning for the winner.
module knn_vote_hist #(
  parameter int N_CLASSES = 10,
  parameter int CNT_W     = 4,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic [CNT_W-1:0] inc_pos,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] rd_first
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r   [N_CLASSES];
  logic [CNT_W-1:0] first_r [N_CLASSES];

  // Count votes; the first vote for a class pins its nearest position.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        cnt_r[i]   <= '0;
        first_r[i] <= '0;
      end
    end else if (inc) begin
      if (cnt_r[inc_idx] == '0) begin
        first_r[inc_idx] <= inc_pos;
      end
      cnt_r[inc_idx] <= cnt_r[inc_idx] + CNT_ONE;
    end
  end

  assign rd_cnt   = cnt_r[rd_idx];
  assign rd_first = first_r[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// knn_vote: collects nearest-first neighbour labels for one job, then scans
// the histogram for the majority class (ties go to the nearer neighbour).
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int HW_K      = KV_HW_K,
  parameter int N_CLASSES = KV_N_CLASSES,
  parameter int LABEL_W   = KV_LABEL_W,
  parameter int CNT_W     = $clog2(HW_K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   k,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] class_out,
  output logic [CNT_W-1:0]   votes_out,
  output logic               err
);

  localparam int IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CNT_W-1:0]   K_MAX     = CNT_W'(HW_K);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_CLASSES - 1);
  localparam logic [LABEL_W-1:0] LABEL_LIM = LABEL_W'(N_CLASSES);

  kv_state_e state_r, state_nxt_s;

  logic [CNT_W-1:0]   k_r, pos_r, best_cnt_r, best_first_r, votes_r;
  logic [CNT_W-1:0]   k_clamp_s, hist_cnt_s, hist_first_s;
  logic [CNT_W-1:0]   best_cnt_nxt_s, best_first_nxt_s;
  logic [IDX_W-1:0]   scan_idx_r, best_c_r, best_c_nxt_s;
  logic [LABEL_W-1:0] class_r;
  logic               err_r;
  logic               start_ok_s, accept_s, last_accept_s, label_ok_s;
  logic               scan_last_s, take_s;

  assign start_ok_s    = (state_r == KV_IDLE) && start;
  assign k_clamp_s     = (k > K_MAX) ? K_MAX : k;
  assign accept_s      = (state_r == KV_COLLECT) && in_valid;
  assign last_accept_s = accept_s && ((pos_r + CNT_ONE) == k_r);
  assign label_ok_s    = (in_label < LABEL_LIM);
  assign scan_last_s   = (state_r == KV_SCAN) && (scan_idx_r == IDX_LAST);

  knn_vote_hist #(
    .N_CLASSES (N_CLASSES),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok_s),
    .inc      (accept_s && label_ok_s),
    .inc_idx  (in_label[IDX_W-1:0]),
    .inc_pos  (pos_r),
    .rd_idx   (scan_idx_r),
    .rd_cnt   (hist_cnt_s),
    .rd_first (hist_first_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= KV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an empty job skips straight to the result.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      KV_IDLE: begin
        if (start) begin
          state_nxt_s = (k_clamp_s == '0) ? KV_DONE : KV_COLLECT;
        end else begin
          state_nxt_s = KV_IDLE;
        end
      end
      KV_COLLECT: begin
        if (last_accept_s) begin
          state_nxt_s = KV_SCAN;
        end else begin
          state_nxt_s = KV_COLLECT;
        end
      end
      KV_SCAN: begin
        if (scan_last_s) begin
          state_nxt_s = KV_DONE;
        end else begin
          state_nxt_s = KV_SCAN;
        end
      end
      KV_DONE: state_nxt_s = KV_IDLE;
      default: state_nxt_s = KV_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_r)
      KV_IDLE:    busy = 1'b0;
      KV_COLLECT: begin busy = 1'b1; in_ready = 1'b1; end
      KV_SCAN:    busy = 1'b1;
      KV_DONE:    begin busy = 1'b1; done = 1'b1; end
      default:    busy = 1'b0;
    endcase
  end

  // Argmax step: a strictly larger count wins, an equal non-zero count wins
  // only if its nearest neighbour sits closer than the current best's.
  always_comb begin
    take_s = (hist_cnt_s > best_cnt_r) ||
             ((hist_cnt_s == best_cnt_r) && (hist_cnt_s != '0) &&
              (hist_first_s < best_first_r));
    if (take_s) begin
      best_c_nxt_s     = scan_idx_r;
      best_cnt_nxt_s   = hist_cnt_s;
      best_first_nxt_s = hist_first_s;
    end else begin
      best_c_nxt_s     = best_c_r;
      best_cnt_nxt_s   = best_cnt_r;
      best_first_nxt_s = best_first_r;
    end
  end

  // Job datapath: latch k, count positions, run the scan and publish the
  // result on the edge into DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r          <= '0;
      pos_r        <= '0;
      scan_idx_r   <= '0;
      best_c_r     <= '0;
      best_cnt_r   <= '0;
      best_first_r <= '1;
      class_r      <= '0;
      votes_r      <= '0;
      err_r        <= 1'b0;
    end else if (start_ok_s) begin
      k_r          <= k_clamp_s;
      pos_r        <= '0;
      scan_idx_r   <= '0;
      best_c_r     <= '0;
      best_cnt_r   <= '0;
      best_first_r <= '1;
      class_r      <= '0;
      votes_r      <= '0;
      err_r        <= 1'b0;
    end else if (accept_s) begin
      pos_r <= pos_r + CNT_ONE;
      if (!label_ok_s) begin
        err_r <= 1'b1;
      end
    end else if (state_r == KV_SCAN) begin
      best_c_r     <= best_c_nxt_s;
      best_cnt_r   <= best_cnt_nxt_s;
      best_first_r <= best_first_nxt_s;
      if (scan_last_s) begin
        scan_idx_r <= '0;
        class_r    <= LABEL_W'(best_c_nxt_s);
        votes_r    <= best_cnt_nxt_s;
      end else begin
        scan_idx_r <= scan_idx_r + IDX_ONE;
      end
    end
  end

  assign class_out = class_r;
  assign votes_out = votes_r;
  assign err       = err_r;

endmodule

// File: tb/tb_knn_vote.sv
// Directed self-checking bench for knn_vote.
module tb_knn_vote;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [3:0] k;
  logic [7:0] in_label;
  logic       in_ready, busy, done, err;
  logic [7:0] class_out;
  logic [3:0] votes_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] labs [0:15];
  int         n_labs;

  always #5 clk = ~clk;

  knn_vote dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .in_label  (in_label),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .class_out (class_out),
    .votes_out (votes_out),
    .err       (err)
  );

  // Called at a negedge: pulse start for one cycle, return at the next negedge.
  task automatic start_job(input logic [3:0] kk);
    start = 1'b1;
    k     = kk;
    @(negedge clk);
    start = 1'b0;
    k     = 4'd0;
  endtask

  // Stream labs[0..n_labs-1] back-to-back, waiting (bounded) on in_ready.
  task automatic send_labels();
    for (int i = 0; i < n_labs; i++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_label = labs[i];
      while (in_ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called one cycle after the last accept; cyc = cycles since that accept.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k = 4'd0; in_label = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (class_out !== 8'd0) $display("FAIL reset_class: got %0d want 0", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd0) $display("FAIL reset_votes: got %0d want 0", votes_out); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    start_job(4'd5);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", in_ready); else n_pass++;
    labs[0] = 8'd3; labs[1] = 8'd3; labs[2] = 8'd7; labs[3] = 8'd3; labs[4] = 8'd1;
    n_labs = 5;
    send_labels();
    wait_done(cyc);
    n_total++; if (cyc != 11) $display("FAIL basic_latency: got %0d want 11", cyc); else n_pass++;
    n_total++; if (class_out !== 8'd3) $display("FAIL basic_class: got %0d want 3", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd3) $display("FAIL basic_votes: got %0d want 3", votes_out); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_tie_break();
    int cyc;
    start_job(4'd4);
    labs[0] = 8'd2; labs[1] = 8'd5; labs[2] = 8'd5; labs[3] = 8'd2;
    n_labs = 4;
    send_labels();
    wait_done(cyc);
    n_total++; if (class_out !== 8'd2) $display("FAIL tie1_class: got %0d want 2", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd2) $display("FAIL tie1_votes: got %0d want 2", votes_out); else n_pass++;
    @(negedge clk);
    start_job(4'd4);
    labs[0] = 8'd5; labs[1] = 8'd2; labs[2] = 8'd2; labs[3] = 8'd5;
    send_labels();
    wait_done(cyc);
    n_total++; if (class_out !== 8'd5) $display("FAIL tie2_class: got %0d want 5", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd2) $display("FAIL tie2_votes: got %0d want 2", votes_out); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_empty_clamp();
    int cyc;
    start_job(4'd0);
    n_total++; if (done !== 1'b1) $display("FAIL empty_done: got %b want 1", done); else n_pass++;
    n_total++; if (class_out !== 8'd0) $display("FAIL empty_class: got %0d want 0", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd0) $display("FAIL empty_votes: got %0d want 0", votes_out); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL empty_idle: got %b want 0", busy); else n_pass++;
    start_job(4'd15);
    labs[0] = 8'd9; labs[1] = 8'd1; labs[2] = 8'd1; labs[3] = 8'd2; labs[4] = 8'd2;
    labs[5] = 8'd2; labs[6] = 8'd9; labs[7] = 8'd9; labs[8] = 8'd9; labs[9] = 8'd4;
    n_labs = 10;
    send_labels();
    n_total++; if (in_ready !== 1'b0) $display("FAIL clamp_ready: got %b want 0", in_ready); else n_pass++;
    // Offer an 11th label that must not be taken.
    in_valid = 1'b1;
    in_label = 8'd2;
    wait_done(cyc);
    in_valid = 1'b0;
    n_total++; if (cyc != 11) $display("FAIL clamp_latency: got %0d want 11", cyc); else n_pass++;
    n_total++; if (class_out !== 8'd9) $display("FAIL clamp_class: got %0d want 9", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd4) $display("FAIL clamp_votes: got %0d want 4", votes_out); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int cyc;
    start_job(4'd3);
    labs[0] = 8'd12; labs[1] = 8'd4; labs[2] = 8'd12;
    n_labs = 3;
    send_labels();
    wait_done(cyc);
    n_total++; if (err !== 1'b1) $display("FAIL oor_err: got %b want 1", err); else n_pass++;
    n_total++; if (class_out !== 8'd4) $display("FAIL oor_class: got %0d want 4", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd1) $display("FAIL oor_votes: got %0d want 1", votes_out); else n_pass++;
    @(negedge clk);
    start_job(4'd2);
    n_total++; if (err !== 1'b0) $display("FAIL oor_clear: got %b want 0", err); else n_pass++;
    labs[0] = 8'd10; labs[1] = 8'd200;
    n_labs = 2;
    send_labels();
    wait_done(cyc);
    n_total++; if (err !== 1'b1) $display("FAIL allbad_err: got %b want 1", err); else n_pass++;
    n_total++; if (class_out !== 8'd0) $display("FAIL allbad_class: got %0d want 0", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd0) $display("FAIL allbad_votes: got %0d want 0", votes_out); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_handshake();
    int cyc;
    start_job(4'd3);
    n_total++; if (err !== 1'b0) $display("FAIL hs_err_clear: got %b want 0", err); else n_pass++;
    in_valid = 1'b1; in_label = 8'd8;
    @(negedge clk);
    // Gap with a stale label present and a stray start.
    in_valid = 1'b0; start = 1'b1; k = 4'd1;
    @(negedge clk);
    start = 1'b0; k = 4'd0;
    in_valid = 1'b1; in_label = 8'd20;
    @(negedge clk);
    n_total++; if (err !== 1'b1) $display("FAIL hs_err_set: got %b want 1", err); else n_pass++;
    in_valid = 1'b0; in_label = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL hs_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL hs_err_kept: got %b want 1", err); else n_pass++;
    in_valid = 1'b1; in_label = 8'd8;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(cyc);
    n_total++; if (cyc != 11) $display("FAIL hs_latency: got %0d want 11", cyc); else n_pass++;
    n_total++; if (class_out !== 8'd8) $display("FAIL hs_class: got %0d want 8", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd2) $display("FAIL hs_votes: got %0d want 2", votes_out); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_job(4'd5);
    labs[0] = 8'd3; labs[1] = 8'd50;
    n_labs = 2;
    send_labels();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (class_out !== 8'd0) $display("FAIL rmid_class: got %0d want 0", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd0) $display("FAIL rmid_votes: got %0d want 0", votes_out); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rmid_err: got %b want 0", err); else n_pass++;
    start_job(4'd1);
    labs[0] = 8'd6;
    n_labs = 1;
    send_labels();
    wait_done(cyc);
    n_total++; if (cyc != 11) $display("FAIL fresh_latency: got %0d want 11", cyc); else n_pass++;
    n_total++; if (class_out !== 8'd6) $display("FAIL fresh_class: got %0d want 6", class_out); else n_pass++;
    n_total++; if (votes_out !== 4'd1) $display("FAIL fresh_votes: got %0d want 1", votes_out); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_break();
    test_empty_clamp();
    test_out_of_range();
    test_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
